// File: rtl/uart_host_port_pkg.sv
// Shared bus types and UART register map for the UART host port and its clients.
package uart_host_port_pkg;

    localparam int XLEN        = 32;
    localparam int PADDR_WIDTH = 32;
    localparam int ID_WIDTH    = 4;

    typedef struct packed {
        logic                   valid;
        logic [PADDR_WIDTH-1:0] paddr;
        logic                   is_write;
        logic [XLEN-1:0]        data;
        logic [ID_WIDTH-1:0]    id;
    } device_req_t;

    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     data;
        logic [ID_WIDTH-1:0] id;
    } device_res_t;

    // 16550 register offsets within the UART window
    localparam logic [PADDR_WIDTH-1:0] UART_RHR_THR = 32'd0;
    localparam logic [PADDR_WIDTH-1:0] UART_IER     = 32'd1;
    localparam logic [PADDR_WIDTH-1:0] UART_ISR_FCR = 32'd2;
    localparam logic [PADDR_WIDTH-1:0] UART_LCR     = 32'd3;
    localparam logic [PADDR_WIDTH-1:0] UART_LSR     = 32'd5;

    localparam int LSR_RHR_READY = 0;
    localparam int LSR_THR_ROOM  = 5;

    typedef enum logic {
        SIDE_RX = 1'b0,
        SIDE_TX = 1'b1
    } side_e;

    function automatic device_req_t mmio_req(
        input logic [PADDR_WIDTH-1:0] paddr,
        input logic                   is_write,
        input logic [XLEN-1:0]        data,
        input logic [ID_WIDTH-1:0]    id
    );
        device_req_t r;
        r.valid    = 1'b1;
        r.paddr    = paddr;
        r.is_write = is_write;
        r.data     = data;
        r.id       = id;
        return r;
    endfunction

endpackage

// File: rtl/uart_host_port.sv
// MMIO initiator that moves bytes between stream ports and a 16550 UART by
// polling LSR, writing THR and reading RHR, one bus request outstanding at a time.
module uart_host_port
    import uart_host_port_pkg::*;
#(
    parameter logic [PADDR_WIDTH-1:0] UART_BASE     = 32'h1000_0000,
    parameter logic [ID_WIDTH-1:0]    REQ_ID        = '0,
    parameter int                     POLL_INTERVAL = 1000,
    parameter int                     RESP_TIMEOUT  = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
    output device_req_t req_out,
    input  device_res_t res_in,
    output logic        busy,
    output logic        timeout_err
);

    localparam int POLL_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int TMO_W  = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_INTERVAL - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LSR,
        WRITE_THR,
        READ_RHR,
        WAIT_RHR
    } state_e;

    state_e            state, state_d;
    logic [POLL_W-1:0] poll_cnt, poll_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_d;
    side_e             last_served, last_served_d;
    device_req_t       req_d;
    logic              tx_ready_d;
    logic              rx_valid_d;
    logic [7:0]        rx_data_d;
    logic              timeout_err_d;

    logic res_match;
    logic rx_elig;
    logic tx_elig;

    assign res_match = res_in.valid && (res_in.id == REQ_ID);
    assign rx_elig   = res_in.data[LSR_RHR_READY] && !rx_valid;
    assign tx_elig   = res_in.data[LSR_THR_ROOM] && tx_valid;
    assign busy      = (state != IDLE);

    always_comb begin
        state_d       = state;
        poll_cnt_d    = poll_cnt;
        tmo_cnt_d     = tmo_cnt;
        last_served_d = last_served;
        req_d         = '0;
        tx_ready_d    = 1'b0;
        timeout_err_d = 1'b0;
        rx_valid_d    = rx_valid && !rx_ready;
        rx_data_d     = rx_data;

        case (state)
            IDLE: begin
                if (tx_valid || (poll_cnt == POLL_LAST)) begin
                    req_d      = mmio_req(UART_BASE + UART_LSR, 1'b0, '0, REQ_ID);
                    poll_cnt_d = '0;
                    tmo_cnt_d  = '0;
                    state_d    = WAIT_LSR;
                end else begin
                    poll_cnt_d = poll_cnt + 1'b1;
                end
            end

            WAIT_LSR: begin
                if (res_match) begin
                    // When both sides are ready, the one not served last time wins
                    if (rx_elig && (!tx_elig || (last_served == SIDE_TX))) begin
                        last_served_d = SIDE_RX;
                        state_d       = READ_RHR;
                    end else if (tx_elig) begin
                        last_served_d = SIDE_TX;
                        state_d       = WRITE_THR;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt + 1'b1;
                end
            end

            WRITE_THR: begin
                req_d      = mmio_req(UART_BASE + UART_RHR_THR, 1'b1, XLEN'(tx_data), REQ_ID);
                tx_ready_d = 1'b1;
                state_d    = IDLE;
            end

            READ_RHR: begin
                req_d     = mmio_req(UART_BASE + UART_RHR_THR, 1'b0, '0, REQ_ID);
                tmo_cnt_d = '0;
                state_d   = WAIT_RHR;
            end

            WAIT_RHR: begin
                if (res_match) begin
                    rx_data_d  = res_in.data[7:0];
                    rx_valid_d = 1'b1;
                    state_d    = IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            poll_cnt    <= '0;
            tmo_cnt     <= '0;
            last_served <= SIDE_RX;
            req_out     <= '0;
            tx_ready    <= 1'b0;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            poll_cnt    <= poll_cnt_d;
            tmo_cnt     <= tmo_cnt_d;
            last_served <= last_served_d;
            req_out     <= req_d;
            tx_ready    <= tx_ready_d;
            rx_valid    <= rx_valid_d;
            rx_data     <= rx_data_d;
            timeout_err <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_uart_host_port.sv
// Bench for uart_host_port: a UART register model answers the bus, queues score TX/RX bytes.
module tb_uart_host_port;
    import uart_host_port_pkg::*;

    localparam logic [PADDR_WIDTH-1:0] BASE = 32'h1000_0000;
    localparam logic [PADDR_WIDTH-1:0] LSR_ADDR = 32'h1000_0005;
    localparam logic [ID_WIDTH-1:0]    RID  = 4'd0;
    localparam int PI = 1000;
    localparam int RT = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, busy, timeout_err;
    logic [7:0]  tx_data, rx_data;
    device_req_t req_out;
    device_res_t res_in;

    uart_host_port #(.UART_BASE(BASE), .REQ_ID(RID), .POLL_INTERVAL(PI), .RESP_TIMEOUT(RT)) dut (
        .clock(clock), .reset(reset),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .req_out(req_out), .res_in(res_in),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // UART model and scoreboard state
    logic [7:0]  uart_fifo[$];
    logic [7:0]  tx_src[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  exp_rx[$];
    device_res_t man_q[$];
    bit thr_room, auto_resp, bogus_en, rand_room, rx_accept, rx_rand, tx_gap_en;
    int rhr_reads = 0;
    int thr_writes = 0;
    int tmo_pulses = 0;

    task automatic send_manual(input logic [31:0] data, input logic [ID_WIDTH-1:0] id);
        device_res_t r;
        r.valid = 1'b1;
        r.data  = data;
        r.id    = id;
        man_q.push_back(r);
    endtask

    // Bus responder: answers reads after a random latency, scores writes
    initial begin : responder
        bit pend, lsr_tx_ok, lsr_rx_ok;
        int pend_cnt;
        logic [31:0] pend_addr, d;
        logic [7:0] b;
        device_res_t r;
        pend = 0; pend_cnt = 0; pend_addr = '0; lsr_tx_ok = 0; lsr_rx_ok = 0;
        res_in = '0;
        forever begin
            @(posedge clock); #1;
            res_in = '0;
            if (reset) begin
                pend = 0; lsr_tx_ok = 0; lsr_rx_ok = 0;
            end else begin
                if (man_q.size() > 0) begin
                    res_in = man_q.pop_front();
                end else if (pend) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        pend = 0;
                        d = $urandom;
                        if (pend_addr == LSR_ADDR) begin
                            if (rand_room) thr_room = ($urandom_range(0, 3) != 0);
                            d[0] = (uart_fifo.size() != 0);
                            d[5] = thr_room;
                            lsr_rx_ok = d[0];
                            lsr_tx_ok = d[5];
                        end else begin
                            check("rhr_fifo_nonempty", 32'(uart_fifo.size() != 0), 32'd1);
                            b = (uart_fifo.size() != 0) ? uart_fifo.pop_front() : 8'hEE;
                            d[7:0] = b;
                        end
                        r.valid = 1'b1; r.data = d; r.id = RID;
                        res_in = r;
                    end
                end else if (bogus_en && $urandom_range(0, 15) == 0) begin
                    r.valid = 1'b1; r.data = $urandom; r.id = RID + 4'd1;
                    res_in = r;
                end

                if (req_out.valid) begin
                    check("req_id", 32'(req_out.id), 32'(RID));
                    if (req_out.is_write) begin
                        thr_writes++;
                        check("thr_addr", req_out.paddr, BASE);
                        check("tx_ready_with_write", 32'(tx_ready), 32'd1);
                        if (auto_resp) begin
                            check("thr_room_seen", 32'(lsr_tx_ok), 32'd1);
                            lsr_tx_ok = 0;
                        end
                        check("thr_write_expected", 32'(exp_tx.size() != 0), 32'd1);
                        if (exp_tx.size() != 0)
                            check("thr_data", req_out.data, 32'(exp_tx.pop_front()));
                    end else begin
                        check("read_addr_legal", 32'(req_out.paddr == LSR_ADDR || req_out.paddr == BASE), 32'd1);
                        check("one_outstanding", 32'(pend), 32'd0);
                        if (req_out.paddr == LSR_ADDR) check("lsr_read_data", req_out.data, 32'd0);
                        if (req_out.paddr == BASE) begin
                            rhr_reads++;
                            if (auto_resp) begin
                                check("rhr_after_lsr_ready", 32'(lsr_rx_ok), 32'd1);
                                lsr_rx_ok = 0;
                            end
                        end
                        if (auto_resp) begin
                            pend = 1;
                            pend_cnt = $urandom_range(1, 4);
                            pend_addr = req_out.paddr;
                        end
                    end
                end else if (tx_ready) begin
                    check("tx_ready_with_write", 32'(tx_ready), 32'd0);
                end
            end
        end
    end

    // TX byte producer
    initial begin : tx_producer
        int gap;
        gap = 0; tx_valid = 1'b0; tx_data = '0;
        forever begin
            @(posedge clock); #1;
            if (tx_valid && tx_ready) tx_valid = 1'b0;
            if (!tx_valid && tx_src.size() > 0) begin
                if (gap > 0) gap--;
                else begin
                    tx_data = tx_src.pop_front();
                    tx_valid = 1'b1;
                    gap = tx_gap_en ? $urandom_range(0, 3) : 0;
                end
            end
        end
    end

    // RX consumer and RX scoreboard
    initial begin : rx_consumer
        rx_ready = 1'b0;
        forever begin
            @(posedge clock); #1;
            rx_ready = rx_accept && (rx_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
        end
    end

    always @(negedge clock) begin
        if (!reset && rx_valid && rx_ready) begin
            check("rx_byte_expected", 32'(exp_rx.size() != 0), 32'd1);
            if (exp_rx.size() != 0) check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
        end
        if (timeout_err) tmo_pulses++;
    end

    task automatic wait_req(input int bound, output int n);
        n = 0;
        do begin @(negedge clock); n++; end while (!req_out.valid && n < bound);
        check("req_within_bound", 32'(req_out.valid), 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin @(negedge clock); n++; end
        check("idle_within_bound", 32'(busy), 32'd0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : main
        int n, cnt, w0, r0;
        reset = 1'b1;
        auto_resp = 1; bogus_en = 0; rand_room = 0; thr_room = 0;
        rx_accept = 0; rx_rand = 0; tx_gap_en = 0;
        repeat (3) @(negedge clock);
        check("rst_req_out", 32'(req_out == '0), 32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Idle polling cadence
        wait_req(PI + 100, n);
        check("first_poll_cycle", n, 32'd1000);
        check("first_poll_addr", req_out.paddr, LSR_ADDR);
        @(negedge clock);
        wait_idle(20);
        wait_req(PI + 100, n);
        check("repoll_cycle", n, 32'd1000);
        @(negedge clock);
        wait_idle(20);

        // TX 0x41 with room in THR
        thr_room = 1;
        exp_tx.push_back(8'h41); tx_src.push_back(8'h41);
        n = 0;
        while (!tx_valid && n < 5) begin @(negedge clock); n++; end
        wait_req(5, n);
        check("tx_poll_immediate", n, 32'd1);
        check("tx_poll_addr", req_out.paddr, LSR_ADDR);
        n = 0;
        while (!tx_ready && n < 20) begin @(negedge clock); n++; end
        check("tx_ready_seen", 32'(tx_ready), 32'd1);
        check("tx_consumed", exp_tx.size(), 32'd0);
        thr_room = 0;

        // RX 0x5A held, a second byte must not be read while the buffer is full
        uart_fifo.push_back(8'h5A); exp_rx.push_back(8'h5A);
        n = 0;
        while (!rx_valid && n < PI + 100) begin @(negedge clock); n++; end
        check("rx_valid_set", 32'(rx_valid), 32'd1);
        check("rx_data_5a", 32'(rx_data), 32'h5A);
        uart_fifo.push_back(8'h33); exp_rx.push_back(8'h33);
        r0 = rhr_reads;
        wait_req(PI + 100, n);
        @(negedge clock);
        wait_idle(20);
        check("no_rhr_when_full", rhr_reads, r0);
        check("uart_byte_kept", uart_fifo.size(), 32'd1);
        check("rx_data_held", 32'(rx_data), 32'h5A);
        rx_accept = 1;
        n = 0;
        while ((exp_rx.size() != 0 || rx_valid) && n < 2500) begin @(negedge clock); n++; end
        check("rx_drained", exp_rx.size(), 32'd0);

        // Both eligible: alternation after RX was served last
        rx_accept = 0; thr_room = 1;
        wait_idle(20);
        w0 = thr_writes; r0 = rhr_reads;
        uart_fifo.push_back(8'hC3); exp_rx.push_back(8'hC3);
        exp_tx.push_back(8'h99); tx_src.push_back(8'h99);
        exp_tx.push_back(8'h9A); tx_src.push_back(8'h9A);
        n = 0;
        while (thr_writes == w0 && n < 50) begin @(negedge clock); n++; end
        check("alt_first_tx", rhr_reads, r0);
        n = 0;
        while (rhr_reads == r0 && n < 50) begin @(negedge clock); n++; end
        check("alt_second_rx", thr_writes, w0 + 1);
        n = 0;
        while (thr_writes < w0 + 2 && n < 50) begin @(negedge clock); n++; end
        check("alt_third_tx", thr_writes, w0 + 2);
        check("alt_rx_byte", 32'(rx_data), 32'hC3);
        rx_accept = 1;
        n = 0;
        while ((exp_rx.size() != 0 || rx_valid) && n < 100) begin @(negedge clock); n++; end
        thr_room = 0;

        // Timeout, late response, foreign id
        auto_resp = 0;
        wait_idle(20);
        wait_req(PI + 100, n);
        check("tmo_poll_addr", req_out.paddr, LSR_ADDR);
        n = 0;
        do begin @(negedge clock); n++; end while (!timeout_err && n < 100);
        check("timeout_cycles", n, 32'd64);
        check("timeout_idle", 32'(busy), 32'd0);
        @(negedge clock);
        check("timeout_one_cycle", 32'(timeout_err), 32'd0);
        send_manual(32'h21, RID);
        cnt = 0;
        repeat (20) begin
            @(negedge clock);
            if (req_out.valid || busy || rx_valid) cnt++;
        end
        check("late_resp_ignored", cnt, 32'd0);
        wait_req(PI + 100, n);
        send_manual(32'h21, RID + 4'd1);
        cnt = 0;
        repeat (10) begin
            @(negedge clock);
            if (req_out.valid || !busy) cnt++;
        end
        check("foreign_id_ignored", cnt, 32'd0);
        n = 0;
        do begin @(negedge clock); n++; end while (!timeout_err && n < 100);
        check("foreign_id_timeout", 32'(timeout_err), 32'd1);

        // Reset while waiting for RHR
        wait_req(PI + 100, n);
        send_manual(32'h01, RID);
        wait_req(10, n);
        check("rhr_read_addr", req_out.paddr, BASE);
        check("rhr_read_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_req_out", 32'(req_out == '0), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
        check("mid_rst_rx_data", 32'(rx_data), 32'd0);
        check("mid_rst_tx_ready", 32'(tx_ready), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        send_manual(32'h77, RID);
        cnt = 0;
        repeat (10) begin
            @(negedge clock);
            if (rx_valid || busy) cnt++;
        end
        check("post_rst_resp_ignored", cnt, 32'd0);

        // Randomized traffic against the UART model
        auto_resp = 1; bogus_en = 1; rand_room = 1; rx_rand = 1; rx_accept = 1; tx_gap_en = 1;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            uart_fifo.push_back(v); exp_rx.push_back(v);
        end
        for (int i = 0; i < 40; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            tx_src.push_back(v); exp_tx.push_back(v);
        end
        n = 0;
        while ((exp_tx.size() != 0 || exp_rx.size() != 0 || rx_valid) && n < 40000) begin
            @(negedge clock); n++;
        end
        check("rand_tx_done", exp_tx.size(), 32'd0);
        check("rand_rx_done", exp_rx.size(), 32'd0);
        check("thr_write_total", thr_writes, 32'd43);
        check("rhr_read_total", rhr_reads, 32'd24);
        check("timeout_pulses", tmo_pulses, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
